// File: rtl/servidor_leitura_multiporta_pkg.sv
// Shared planner definitions: FSM encodings, default address width
// and the all-ones "no neighbour" address marker.
package servidor_leitura_multiporta_pkg;

   localparam int ADDR_W = 10;

   // Consumers truncate this to their own address width.
   localparam logic [31:0] ADDR_INVALIDO = '1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EMITIR,
      ST_DRENAR,
      ST_PRONTO,
      ST_LIMPAR
   } estado_t;

endpackage

// File: rtl/servidor_leitura_multiporta_memoria_sp.sv
// Single-port RAM, one access per cycle, registered read data.
// Contents are deliberately not reset.
module memoria_sp #(
   parameter int AW = 10,
   parameter int DW = 1
) (
   input  logic          clk,
   input  logic          en,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wr_data,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[addr] <= wr_data;
         end
         rd_data <= mem[addr];
      end
   end

endmodule

// File: rtl/servidor_leitura_multiporta.sv
// Multi-port read server: serialises NUM_READ_PORTS lookups onto one
// single-port RAM, with a one-entry write buffer and a full clear.
module servidor_leitura_multiporta
   import servidor_leitura_multiporta_pkg::*;
#(
   parameter int ADDR_WIDTH     = ADDR_W,
   parameter int DATA_WIDTH     = 1,
   parameter int NUM_READ_PORTS = 8
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               rd_enable_in,
   input  logic [ADDR_WIDTH*NUM_READ_PORTS-1:0] rd_addr_in,
   output logic [DATA_WIDTH*NUM_READ_PORTS-1:0] rd_data_out,
   output logic                               rd_ready_out,
   input  logic                               wr_enable_in,
   input  logic [ADDR_WIDTH-1:0]              wr_addr_in,
   input  logic [DATA_WIDTH-1:0]              wr_data_in,
   output logic                               wr_ready_out,
   input  logic                               limpar_in,
   output logic                               ocupado_out
);

   localparam int PW = (NUM_READ_PORTS > 1) ? $clog2(NUM_READ_PORTS) : 1;
   localparam logic [ADDR_WIDTH-1:0] INVALIDO = ADDR_INVALIDO[ADDR_WIDTH-1:0];
   localparam logic [PW-1:0] ULTIMA = PW'(NUM_READ_PORTS - 1);

   estado_t estado, prox;

   logic [ADDR_WIDTH-1:0] addr_lat [NUM_READ_PORTS];
   logic [PW-1:0]         porta;
   logic [ADDR_WIDTH-1:0] cnt_limpar;

   logic                  pend_v;
   logic [ADDR_WIDTH-1:0] pend_addr;
   logic [DATA_WIDTH-1:0] pend_data;

   logic                  cap_v;
   logic                  cap_inv;
   logic [PW-1:0]         cap_idx;
   logic [DATA_WIDTH*NUM_READ_PORTS-1:0] dados_q;

   logic                  mem_en;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;

   logic [ADDR_WIDTH-1:0] addr_atual;
   logic                  invalido;
   logic                  aceita_rd;
   logic                  wr_aceito;

   assign addr_atual   = addr_lat[porta];
   assign invalido     = (addr_atual == INVALIDO);
   assign aceita_rd    = (estado == ST_IDLE) && rd_enable_in && !limpar_in;
   assign wr_aceito    = wr_enable_in && !pend_v;

   assign ocupado_out  = (estado != ST_IDLE);
   assign rd_ready_out = (estado == ST_PRONTO);
   assign wr_ready_out = !pend_v;
   assign rd_data_out  = dados_q;

   always_comb begin
      prox = estado;
      unique case (estado)
         ST_IDLE: begin
            if (limpar_in) begin
               prox = ST_LIMPAR;
            end else if (rd_enable_in) begin
               prox = ST_EMITIR;
            end
         end
         ST_EMITIR: if (porta == ULTIMA) prox = ST_DRENAR;
         ST_DRENAR: prox = ST_PRONTO;
         ST_PRONTO: prox = ST_IDLE;
         ST_LIMPAR: if (cnt_limpar == INVALIDO) prox = ST_IDLE;
         default:   prox = ST_IDLE;
      endcase
   end

   // The buffered write always wins the RAM in IDLE; a new write waits.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = addr_atual;
      mem_wdata = pend_data;
      unique case (estado)
         ST_IDLE: begin
            if (pend_v) begin
               mem_en   = 1'b1;
               mem_we   = 1'b1;
               mem_addr = pend_addr;
            end else if (wr_enable_in) begin
               mem_en    = 1'b1;
               mem_we    = 1'b1;
               mem_addr  = wr_addr_in;
               mem_wdata = wr_data_in;
            end
         end
         ST_EMITIR: mem_en = !invalido;
         ST_LIMPAR: begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = cnt_limpar;
            mem_wdata = '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado     <= ST_IDLE;
         porta      <= '0;
         cnt_limpar <= '0;
         pend_v     <= 1'b0;
         pend_addr  <= '0;
         pend_data  <= '0;
         cap_v      <= 1'b0;
         cap_inv    <= 1'b0;
         cap_idx    <= '0;
         dados_q    <= '0;
         for (int i = 0; i < NUM_READ_PORTS; i++) begin
            addr_lat[i] <= '0;
         end
      end else begin
         estado <= prox;
         cap_v  <= 1'b0;
         if (aceita_rd) begin
            for (int i = 0; i < NUM_READ_PORTS; i++) begin
               addr_lat[i] <= rd_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
         end
         if (estado == ST_IDLE) begin
            porta      <= '0;
            cnt_limpar <= '0;
         end
         if (estado == ST_EMITIR) begin
            porta   <= porta + 1'b1;
            cap_v   <= 1'b1;
            cap_idx <= porta;
            cap_inv <= invalido;
         end
         if (estado == ST_LIMPAR && cnt_limpar != INVALIDO) begin
            cnt_limpar <= cnt_limpar + 1'b1;
         end
         // RAM word arrives one cycle after issue.
         if (cap_v) begin
            for (int i = 0; i < NUM_READ_PORTS; i++) begin
               if (cap_idx == PW'(i)) begin
                  dados_q[i*DATA_WIDTH +: DATA_WIDTH] <= cap_inv ? '0 : mem_rdata;
               end
            end
         end
         if (estado == ST_IDLE) begin
            pend_v <= 1'b0;
         end else if (wr_aceito) begin
            pend_v    <= 1'b1;
            pend_addr <= wr_addr_in;
            pend_data <= wr_data_in;
         end
      end
   end

   memoria_sp #(
      .AW (ADDR_WIDTH),
      .DW (DATA_WIDTH)
   ) u_mem (
      .clk     (clk),
      .en      (mem_en),
      .we      (mem_we),
      .addr    (mem_addr),
      .wr_data (mem_wdata),
      .rd_data (mem_rdata)
   );

endmodule

// File: doc/servidor_leitura_multiporta.md
SERVIDOR_LEITURA_MULTIPORTA -- requirements
Module: servidor_leitura_multiporta

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 10, node address width; DATA_WIDTH, default 1, stored word width; NUM_READ_PORTS, default 8, addresses per read request.
REQ-002 clk  input  1  clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 rd_enable_in  input  1  read-request pulse.
REQ-005 rd_addr_in  input  ADDR_WIDTH*NUM_READ_PORTS  packed addresses; port i at [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-006 rd_data_out  output  DATA_WIDTH*NUM_READ_PORTS  packed results; port i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 rd_ready_out  output  1  one-cycle pulse; rd_data_out is valid.
REQ-008 wr_enable_in, wr_addr_in, wr_data_in  input  1 / ADDR_WIDTH / DATA_WIDTH  single-word write request.
REQ-009 wr_ready_out  output  1  write can be accepted.
REQ-010 limpar_in  input  1  pulse; zero the entire memory.
REQ-011 ocupado_out  output  1  high in every non-IDLE state.

Function
REQ-012 Storage SHALL be 2^ADDR_WIDTH x DATA_WIDTH single-port RAM with 1-cycle registered read latency; one access per cycle.
REQ-013 FSM states SHALL be: ST_IDLE, ST_EMITIR, ST_DRENAR, ST_PRONTO, ST_LIMPAR.
REQ-014 In ST_IDLE, limpar_in SHALL take priority: go to ST_LIMPAR; a simultaneous rd_enable_in is ignored.
REQ-015 In ST_IDLE, rd_enable_in without limpar_in SHALL latch rd_addr_in and go to ST_EMITIR.
REQ-016 rd_enable_in and limpar_in arriving while ocupado_out=1 SHALL be ignored.
REQ-017 ST_EMITIR SHALL issue port 0..NUM_READ_PORTS-1 addresses, one per cycle, in ascending order, then go to ST_DRENAR.
REQ-018 A port address of all ones (inexistent neighbour) SHALL NOT access the RAM, and its result SHALL be 0.
REQ-019 Each returned word SHALL be captured into its port slot of rd_data_out one cycle after issue; ST_DRENAR captures the last word, then go to ST_PRONTO.
REQ-020 ST_PRONTO SHALL assert rd_ready_out for exactly one cycle, then go to ST_IDLE.
REQ-021 rd_ready_out SHALL be high exactly NUM_READ_PORTS+2 cycles after the edge that accepted rd_enable_in.
REQ-022 rd_data_out SHALL hold its value until the next capture.
REQ-023 ST_LIMPAR SHALL write 0 to addresses 0..2^ADDR_WIDTH-1 ascending, one per cycle; the address counter SHALL NOT wrap, and the block SHALL go to ST_IDLE after the last address.
REQ-024 Writes SHALL be accepted when wr_enable_in and wr_ready_out are both high.
REQ-025 In ST_IDLE, an accepted write SHALL be performed in the same cycle; a read accepted in that cycle observes the new value.
REQ-026 In other states, an accepted write SHALL go to a one-entry pending buffer, and wr_ready_out SHALL be low while the buffer is full.
REQ-027 The pending write SHALL execute in the first ST_IDLE cycle, before any incoming write, and SHALL survive a preceding ST_LIMPAR.
REQ-028 wr_enable_in while wr_ready_out=0 SHALL be dropped; this is illegal use.
REQ-029 In ST_IDLE with the buffer full, wr_ready_out SHALL be low; the buffered write executes and the new write waits one cycle.

Reset
REQ-030 On rst_n low, the state SHALL become ST_IDLE.
REQ-031 On rst_n low: rd_data_out=0, rd_ready_out=0, ocupado_out=0, wr_ready_out=1, pending buffer empty, counters 0.
REQ-032 RAM contents SHALL NOT be reset.
REQ-033 Reset mid-read or mid-limpar SHALL abort the operation without producing a ready pulse.

Structure
REQ-034 State encodings and the invalid-address constant (all ones) SHALL live in the shared planner package, with ADDR_WIDTH consistent with the expander blocks.
REQ-035 The RAM SHALL be a sub-module named memoria_sp (clk, en, we, addr, wr_data, rd_data).
REQ-036 The FSM, port counter, pending buffer and result capture SHALL be in this module.

Verification (NUM_READ_PORTS=8, ADDR_WIDTH=10, DATA_WIDTH=1)
REQ-037 Write 1 to addresses 5 and 9, then read {5,9,0,1,2,3,4,6} -> rd_ready_out 10 cycles after accept; rd_data_out=8'b00000011.
REQ-038 Read with port 3 = 10'h3FF and memory address 1023 preloaded to 1 -> port 3 result 0; no RAM enable for that slot.
REQ-039 Write to address 7 during ST_EMITIR -> wr_ready_out low until executed in the next ST_IDLE; a following read of 7 returns 1.
REQ-040 limpar_in and rd_enable_in in the same cycle -> 1024-cycle clear, no ready pulse, all subsequent reads return 0.
REQ-041 rst_n asserted at cycle 4 of ST_EMITIR -> outputs at reset values immediately; no rd_ready_out pulse.
REQ-042 Simultaneous wr (addr 2, data 1) and rd of addr 2 in ST_IDLE -> port result 1.
